// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of hazard-detection inputs and stall/MD-sequencer outputs shared
// between the pipeline datapath (master) and the stall controller (slave).
interface hazard_stall_ctrl_if #(
   parameter int CNT_W = 4
);
   logic [4:0]       D_rs;
   logic [4:0]       D_rt;
   logic [1:0]       D_rs_tuse;
   logic [1:0]       D_rt_tuse;
   logic             D_is_md;
   logic [4:0]       E_wa;
   logic [1:0]       E_tnew;
   logic [4:0]       M_wa;
   logic [1:0]       M_tnew;
   logic             E_md_start;
   logic             E_md_div;
   logic             F_pause;
   logic             D_pause;
   logic             E_flush;
   logic             md_busy;
   logic [CNT_W-1:0] md_cnt;
   logic             md_err;

   modport master (
      output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
      output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
      input  F_pause, D_pause, E_flush, md_busy, md_cnt, md_err
   );

   modport slave (
      input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
      input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
      output F_pause, D_pause, E_flush, md_busy, md_cnt, md_err
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew RAW hazard detection plus the
// multiply/divide busy sequencer that holds HI/LO instructions in D.
module hazard_stall_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
) (
   input logic clk,
   input logic reset,
   hazard_stall_ctrl_if.slave hz
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdState_t;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   mdState_t         r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   logic w_stallRs;
   logic w_stallRt;
   logic w_stallMd;
   logic w_stall;

   // A producer stalls D only when its result arrives later than D needs it.
   assign w_stallRs = (hz.D_rs != 5'd0) &&
                      (((hz.D_rs == hz.E_wa) && (hz.E_tnew > hz.D_rs_tuse)) ||
                       ((hz.D_rs == hz.M_wa) && (hz.M_tnew > hz.D_rs_tuse)));
   assign w_stallRt = (hz.D_rt != 5'd0) &&
                      (((hz.D_rt == hz.E_wa) && (hz.E_tnew > hz.D_rt_tuse)) ||
                       ((hz.D_rt == hz.M_wa) && (hz.M_tnew > hz.D_rt_tuse)));
   assign w_stallMd = hz.D_is_md && ((r_state == BUSY) || hz.E_md_start);
   assign w_stall   = reset && (w_stallRs || w_stallRt || w_stallMd);

   assign hz.F_pause = w_stall;
   assign hz.D_pause = w_stall;
   assign hz.E_flush = w_stall;
   assign hz.md_busy = (r_state == BUSY);
   assign hz.md_cnt  = r_cnt;
   assign hz.md_err  = r_err;

   // Starts seen while busy, including on the expiring cycle, are dropped and flagged.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (hz.E_md_start) begin
                  r_state <= BUSY;
                  r_cnt   <= hz.E_md_div ? DIV_LOAD : MULT_LOAD;
               end else begin
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               if (hz.E_md_start) begin
                  r_err <= 1'b1;
               end
               if (r_cnt <= CNT_ONE) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl: RAW stalls, $0 immunity,
// mult/div busy sequencing, busy-start error flag and mid-operation reset.
module tb_hazard_stall_ctrl;

   localparam int CNT_W = 4;

   logic clk;
   logic reset;
   int   nAsserts;
   int   nFails;

   hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hz ();

   hazard_stall_ctrl #(
      .MULT_CYC(5),
      .DIV_CYC (10),
      .CNT_W   (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .hz   (hz.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(
      input logic [4:0] rs, input logic [1:0] rsTuse,
      input logic [4:0] rt, input logic [1:0] rtTuse,
      input logic [4:0] eWa, input logic [1:0] eTnew,
      input logic [4:0] mWa, input logic [1:0] mTnew,
      input logic isMd, input logic start, input logic isDiv
   );
      hz.D_rs       = rs;
      hz.D_rs_tuse  = rsTuse;
      hz.D_rt       = rt;
      hz.D_rt_tuse  = rtTuse;
      hz.E_wa       = eWa;
      hz.E_tnew     = eTnew;
      hz.M_wa       = mWa;
      hz.M_tnew     = mTnew;
      hz.D_is_md    = isMd;
      hz.E_md_start = start;
      hz.E_md_div   = isDiv;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkStall(input string tag, input logic expected);
      checkOutput({tag, ".F_pause"}, {31'd0, hz.F_pause}, {31'd0, expected});
      checkOutput({tag, ".D_pause"}, {31'd0, hz.D_pause}, {31'd0, expected});
      checkOutput({tag, ".E_flush"}, {31'd0, hz.E_flush}, {31'd0, expected});
   endtask

   task automatic checkMd(input string tag, input logic busy,
                          input logic [CNT_W-1:0] cnt, input logic err);
      checkOutput({tag, ".md_busy"}, {31'd0, hz.md_busy}, {31'd0, busy});
      checkOutput({tag, ".md_cnt"},  {28'd0, hz.md_cnt},  {28'd0, cnt});
      checkOutput({tag, ".md_err"},  {31'd0, hz.md_err},  {31'd0, err});
   endtask

   // Linear directed sequence; each step drives inputs just after a rising edge.
   initial begin
      nAsserts = 0;
      nFails   = 0;
      reset    = 1'b0;
      applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      checkMd("reset", 1'b0, 4'd0, 1'b0);
      checkStall("reset", 1'b0);
      reset = 1'b1;
      step();

      applyStimulus(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      checkStall("loadUse", 1'b1);
      applyStimulus(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      checkStall("tnewEqTuse", 1'b0);
      applyStimulus(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
      checkStall("bothEM", 1'b1);
      applyStimulus(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      checkStall("reg0", 1'b0);
      applyStimulus(5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
      checkStall("mStageRt", 1'b1);
      applyStimulus(5'd0, 2'd3, 5'd7, 2'd3, 5'd0, 2'd0, 5'd7, 2'd3, 1'b0, 1'b0, 1'b0);
      checkStall("rtUnused", 1'b0);

      // Mult followed by a HI/LO instruction waiting in D.
      applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      checkStall("multStartCycle", 1'b1);
      checkMd("multStartCycle", 1'b0, 4'd0, 1'b0);
      for (int k = 5; k >= 1; k--) begin
         step();
         applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
         checkMd($sformatf("multBusy%0d", k), 1'b1, 4'(k), 1'b0);
         checkStall($sformatf("multBusy%0d", k), 1'b1);
         if (k == 3) begin
            applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            checkStall("nonMdWhileBusy", 1'b0);
            applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
         end
      end
      step();
      checkMd("multDone", 1'b0, 4'd0, 1'b0);
      checkStall("multRelease", 1'b0);

      // Div with an illegal second start on the fourth busy cycle.
      applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         step();
         applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0,
                       (c == 4) ? 1'b1 : 1'b0, 1'b0);
         checkMd($sformatf("divBusy%0d", c), 1'b1, 4'(11 - c), (c >= 5) ? 1'b1 : 1'b0);
         checkStall($sformatf("divNonMd%0d", c), 1'b0);
      end
      step();
      checkMd("divDone", 1'b0, 4'd0, 1'b1);
      step();
      checkMd("errSticky", 1'b0, 4'd0, 1'b1);

      // Reset asserted on the third busy cycle of a div.
      applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
      step();
      applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      checkMd("divCycle3", 1'b1, 4'd8, 1'b1);
      reset = 1'b0;
      applyStimulus(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      checkStall("resetHeld", 1'b0);
      step();
      checkMd("resetAbort", 1'b0, 4'd0, 1'b0);
      checkStall("resetHeld2", 1'b0);
      reset = 1'b1;
      applyStimulus(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      checkStall("afterReset", 1'b1);
      step();
      checkMd("afterResetIdle", 1'b0, 4'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
